simon_pattern_sequencer: RTL
============================

// Module: simon_pattern_sequencer
// PURPOSE
//  Sequences the Simon pattern register file on behalf of the top-level game FSM.
//  - Executes four commands: CLEAR, APPEND, PLAYBACK and CHECK.
//  - Owns the level count and the read/write address counters.
//  - Paces playback so each entry is displayed for a fixed number of cycles.
//  - Compares user entries against stored entries.
//  - Replaces the ad-hoc counter/current enable and reset strobes with one command handshake.
// PARAMETERS
//  DEPTH          64  number of pattern slots (maximum level)
//  AW             6   address width, clog2(DEPTH)
//  PW             4   pattern width in bits
//  HOLD_CYCLES    4   display cycles per entry during playback (>=1)
//  TIMEOUT_CYCLES 255 idle cycles allowed per CHECK entry (used only with macro)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-low
//  cmd_valid    in   1      command request
//  cmd_op       in   2      00 CLEAR, 01 APPEND, 10 PLAYBACK, 11 CHECK
//  cmd_ready    out  1      command accepted when cmd_valid & cmd_ready
//  in_pattern   in   PW     user pattern (APPEND data / CHECK entry)
//  in_valid     in   1      one-cycle strobe: user entry present (CHECK only)
//  mem_we       out  1      pattern memory write enable
//  mem_addr     out  AW     pattern memory address
//  mem_wdata    out  PW     pattern memory write data
//  mem_rdata    in   PW     pattern memory read data, valid 1 cycle after mem_addr
//  disp_pattern out  PW     pattern to display during playback
//  disp_valid   out  1      disp_pattern meaningful
//  level        out  AW+1   number of stored entries, 0..DEPTH
//  done         out  1      one-cycle pulse: command complete
//  pass         out  1      result of last command, valid from the done cycle until the next accept
// BEHAVIOUR
//  Reset (rst=0 at clk edge):
//   - state IDLE; level=0; mem_we=0; mem_addr=0; disp_valid=0; done=0; pass=0; cmd_ready=1.
//   - Reset mid-command aborts the command: no done pulse, no memory write.
//  States: IDLE, APPEND, PLAY_FETCH, PLAY_HOLD, CHK_FETCH, CHK_WAIT, FINISH.
//   - cmd_ready=1 only in IDLE.
//   - in_pattern is captured at accept for APPEND and is ignored afterwards.
//   - in_valid is ignored outside CHK_WAIT.
//  CLEAR: IDLE->FINISH; level<=0; pass=1.
//  APPEND:
//   - level==DEPTH: FINISH with pass=0; no write; level unchanged.
//   - otherwise APPEND holds mem_we=1 for exactly 1 cycle with addr=level and
//     wdata=captured pattern; level increments; FINISH with pass=1.
//  PLAYBACK:
//   - level==0: FINISH with pass=1.
//   - otherwise, for idx 0..level-1: PLAY_FETCH (1 cycle, mem_addr=idx), then
//     PLAY_HOLD for HOLD_CYCLES cycles with disp_valid=1 and disp_pattern=rdata latched at hold entry.
//   - Each entry takes HOLD_CYCLES+1 cycles. After the last hold cycle: FINISH, pass=1.
//  CHECK:
//   - level==0: FINISH with pass=1.
//   - per idx: CHK_FETCH (1 cycle), then CHK_WAIT until in_valid.
//   - in_pattern!=stored entry: FINISH with pass=0 immediately; remaining entries are skipped.
//   - All level entries match: FINISH with pass=1. level is unchanged by CHECK.
//  FINISH: done=1 for 1 cycle, then IDLE.
//  Arithmetic: idx is AW+1 bits and never wraps; comparison uses idx==level-1. The hold counter saturates at 0.
// CONFIGURATION
//  SIMON_SEQ_TIMEOUT_EN:
//   - defined: a CHK_WAIT counter reloads on CHK_WAIT entry and counts idle cycles.
//     After TIMEOUT_CYCLES cycles without in_valid: FINISH with pass=0.
//     in_valid on the final allowed cycle is still compared.
//   - undefined: no timer logic; CHK_WAIT waits indefinitely.
// STRUCTURE
//  Package simon_seq_pkg: cmd_op encodings (OP_CLEAR/OP_APPEND/OP_PLAYBACK/OP_CHECK)
//  and state encoding localparams.
//  Sub-module simon_hold_timer: loadable down-counter with zero flag. Used for
//  HOLD_CYCLES and reused for the timeout counter.
// TESTING
//  1. rst=0 for 1 edge during PLAYBACK -> next cycle IDLE, level=0, done=0, disp_valid=0, cmd_ready=1.
//  2. CLEAR; APPEND 4'hA; APPEND 4'h3 -> mem writes at addr 0 and 1; level=2; two done pulses, pass=1.
//  3. PLAYBACK at level=2, HOLD_CYCLES=4 -> disp 4'hA for 4 cycles, gap 1 cycle, disp 4'h3 for 4 cycles;
//     done 11 cycles after accept; pass=1.
//  4. CHECK with entries A,3 -> pass=1; repeat with entries A,5 -> done the cycle after the 2nd
//     in_valid with pass=0; level stays 2.
//  5. Fill to DEPTH=64, then APPEND -> pass=0, mem_we never asserted, level=64.
//     PLAYBACK/CHECK at level=0 -> done on the 2nd cycle after accept, pass=1.
//  6. With SIMON_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: CHECK with no in_valid -> pass=0 after 8 idle
//     cycles; without the macro -> no done after 1000 cycles.

Source files
------------

// File: rtl/simon_seq_pkg.sv
// Purpose: shared command encodings and FSM state encoding for the Simon pattern sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_seq_pkg;

    localparam logic [1:0] OP_CLEAR    = 2'b00;
    localparam logic [1:0] OP_APPEND   = 2'b01;
    localparam logic [1:0] OP_PLAYBACK = 2'b10;
    localparam logic [1:0] OP_CHECK    = 2'b11;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_APPEND     = 3'd1;
    localparam logic [2:0] ST_PLAY_FETCH = 3'd2;
    localparam logic [2:0] ST_PLAY_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHK_FETCH  = 3'd4;
    localparam logic [2:0] ST_CHK_WAIT   = 3'd5;
    localparam logic [2:0] ST_FINISH     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_APPEND     = ST_APPEND,
        S_PLAY_FETCH = ST_PLAY_FETCH,
        S_PLAY_HOLD  = ST_PLAY_HOLD,
        S_CHK_FETCH  = ST_CHK_FETCH,
        S_CHK_WAIT   = ST_CHK_WAIT,
        S_FINISH     = ST_FINISH
    } state_t;

endpackage

// File: rtl/simon_hold_timer.sv
// Purpose: loadable down-counter with zero flag; paces playback holds and CHECK timeouts.
// Latency: load takes effect the cycle after i_load; o_zero is combinational from the count.
// Backpressure: none; decrements saturate at zero.
module simon_hold_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/simon_pattern_sequencer.sv
// Purpose: runs CLEAR/APPEND/PLAYBACK/CHECK on the Simon pattern memory; owns level and addresses.
// Latency: CLEAR 1 cycle, APPEND 2, PLAYBACK 1+level*(HOLD_CYCLES+1), CHECK waits on user entries.
// Backpressure: o_cmd_ready only in IDLE; optional CHECK timeout enabled by SIMON_SEQ_TIMEOUT_EN.
module simon_pattern_sequencer
    import simon_seq_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int AW             = 6,
    parameter int PW             = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    input  logic [1:0]    i_cmd_op,
    output logic          o_cmd_ready,
    input  logic [PW-1:0] i_in_pattern,
    input  logic          i_in_valid,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [PW-1:0] o_mem_wdata,
    input  logic [PW-1:0] i_mem_rdata,
    output logic [PW-1:0] o_disp_pattern,
    output logic          o_disp_valid,
    output logic [AW:0]   o_level,
    output logic          o_done,
    output logic          o_pass
);

    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   LVL_MAX   = (AW + 1)'(DEPTH);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (DEPTH > (1 << AW)) begin : g_bad_depth
        $error("DEPTH does not fit in AW address bits");
    end

    state_t        r_state;
    state_t        w_next_state;
    logic [AW:0]   r_level;
    logic [AW:0]   r_idx;
    logic [PW-1:0] r_wdata;
    logic          r_first;
    logic [PW-1:0] r_rdata_q;
    logic          r_pass;

    logic          w_accept;
    logic          w_last;
    logic [PW-1:0] w_stored;
    logic          w_arm;
    logic          w_hold_load;
    logic          w_hold_dec;
    logic          w_hold_zero;
    logic          w_idx_inc;
    logic          w_level_inc;
    logic          w_level_clr;
    logic          w_fin;
    logic          w_fin_pass;

`ifdef SIMON_SEQ_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic w_tmo_load;
    logic w_tmo_dec;
    logic w_tmo_zero;
`endif

    assign w_accept = i_cmd_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == (r_level - 1'b1));
    // Memory read data is only valid in the first cycle after a fetch, so it is
    // forwarded directly then and taken from the latched copy afterwards.
    assign w_stored = r_first ? i_mem_rdata : r_rdata_q;

    assign o_cmd_ready    = (r_state == S_IDLE);
    assign o_done         = (r_state == S_FINISH);
    assign o_disp_valid   = (r_state == S_PLAY_HOLD);
    assign o_disp_pattern = w_stored;
    assign o_mem_addr     = (r_state == S_APPEND) ? r_level[AW-1:0] : r_idx[AW-1:0];
    assign o_mem_wdata    = r_wdata;
    assign o_level        = r_level;
    assign o_pass         = r_pass;

    simon_hold_timer #(.W(HW)) u_hold_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_LOAD),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero)
    );

`ifdef SIMON_SEQ_TIMEOUT_EN
    simon_hold_timer #(.W(TW)) u_tmo_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmo_load),
        .i_load_val (TMO_LOAD),
        .i_dec      (w_tmo_dec),
        .o_zero     (w_tmo_zero)
    );
`endif

    // State register; reset aborts any command in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the per-cycle control strobes for the datapath.
    always_comb begin
        w_next_state = r_state;
        o_mem_we     = 1'b0;
        w_arm        = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_dec   = 1'b0;
        w_idx_inc    = 1'b0;
        w_level_inc  = 1'b0;
        w_level_clr  = 1'b0;
        w_fin        = 1'b0;
        w_fin_pass   = 1'b0;
`ifdef SIMON_SEQ_TIMEOUT_EN
        w_tmo_load   = 1'b0;
        w_tmo_dec    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_cmd_op)
                        OP_CLEAR: begin
                            w_next_state = S_FINISH;
                            w_level_clr  = 1'b1;
                            w_fin        = 1'b1;
                            w_fin_pass   = 1'b1;
                        end
                        OP_APPEND:   w_next_state = S_APPEND;
                        OP_PLAYBACK: w_next_state = S_PLAY_FETCH;
                        default:     w_next_state = S_CHK_FETCH;
                    endcase
                end
            end
            S_APPEND: begin
                w_next_state = S_FINISH;
                w_fin        = 1'b1;
                if (r_level != LVL_MAX) begin
                    o_mem_we    = 1'b1;
                    w_level_inc = 1'b1;
                    w_fin_pass  = 1'b1;
                end
            end
            S_PLAY_FETCH: begin
                if (r_level == '0) begin
                    w_next_state = S_FINISH;
                    w_fin        = 1'b1;
                    w_fin_pass   = 1'b1;
                end else begin
                    w_next_state = S_PLAY_HOLD;
                    w_arm        = 1'b1;
                    w_hold_load  = 1'b1;
                end
            end
            S_PLAY_HOLD: begin
                if (w_hold_zero) begin
                    if (w_last) begin
                        w_next_state = S_FINISH;
                        w_fin        = 1'b1;
                        w_fin_pass   = 1'b1;
                    end else begin
                        w_next_state = S_PLAY_FETCH;
                        w_idx_inc    = 1'b1;
                    end
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            S_CHK_FETCH: begin
                if (r_level == '0) begin
                    w_next_state = S_FINISH;
                    w_fin        = 1'b1;
                    w_fin_pass   = 1'b1;
                end else begin
                    w_next_state = S_CHK_WAIT;
                    w_arm        = 1'b1;
`ifdef SIMON_SEQ_TIMEOUT_EN
                    w_tmo_load   = 1'b1;
`endif
                end
            end
            S_CHK_WAIT: begin
                // A user entry wins over an expiring timer in the same cycle.
                if (i_in_valid) begin
                    if (i_in_pattern != w_stored) begin
                        w_next_state = S_FINISH;
                        w_fin        = 1'b1;
                    end else if (w_last) begin
                        w_next_state = S_FINISH;
                        w_fin        = 1'b1;
                        w_fin_pass   = 1'b1;
                    end else begin
                        w_next_state = S_CHK_FETCH;
                        w_idx_inc    = 1'b1;
                    end
                end
`ifdef SIMON_SEQ_TIMEOUT_EN
                else if (w_tmo_zero) begin
                    w_next_state = S_FINISH;
                    w_fin        = 1'b1;
                end else begin
                    w_tmo_dec = 1'b1;
                end
`endif
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: level/index counters, APPEND data capture, read-data latch and result flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_level   <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_first   <= 1'b0;
            r_rdata_q <= '0;
            r_pass    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx   <= '0;
                r_wdata <= i_in_pattern;
                r_pass  <= 1'b0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_level_clr) begin
                r_level <= '0;
            end else if (w_level_inc) begin
                r_level <= r_level + 1'b1;
            end
            r_first <= w_arm;
            if (r_first) begin
                r_rdata_q <= i_mem_rdata;
            end
            if (w_fin) begin
                r_pass <= w_fin_pass;
            end
        end
    end

endmodule
